multi_cycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle RV32I core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback. Drives instruction and data memory request/ack handshakes, register-file and PC write enables, and the ALU operand, PC-source and writeback selects. The ALU operation itself comes from the secondary decoder, which is fed the same opcode/funct fields.

---
 rtl/multi_cycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Walks one instruction at a time through IF -> ID -> EX -> (MEM) -> (WB)
// and drives the memory handshakes, write enables and datapath selects.
// Optional performance counters are enabled with the MCTRL_PERF_EN macro.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [2:0] state,
    output logic       illegal
`ifdef MCTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_e r_state;
    state_e w_next;

    logic w_is_r, w_is_i, w_is_l, w_is_s, w_is_b;
    logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_supported;

    // Instruction class flags from the IR opcode field.
    always_comb begin
        w_is_r      = (opcode == OP_R);
        w_is_i      = (opcode == OP_I);
        w_is_l      = (opcode == OP_L);
        w_is_s      = (opcode == OP_S);
        w_is_b      = (opcode == OP_B);
        w_is_jal    = (opcode == OP_JAL);
        w_is_jalr   = (opcode == OP_JALR);
        w_is_lui    = (opcode == OP_LUI);
        w_is_auipc  = (opcode == OP_AUIPC);
        w_supported = w_is_r | w_is_i | w_is_l | w_is_s | w_is_b |
                      w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;
    end

    // State register; reset forces the fetch state, abandoning any request.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous (sampled only at the clock edge), and all
        // state updates use non-blocking assignment so every flop sees
        // pre-edge values.
        if (!rst_n) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and all control outputs, decoded from state, opcode and acks.
    always_comb begin
        // NOTE: every output gets a default before the case statement so no
        // path leaves a signal unassigned and no latch is inferred.
        w_next    = r_state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        rf_we     = 1'b0;
        illegal   = 1'b0;

        // Datapath selects follow the opcode in every state; they only
        // matter in EX/MEM/WB.
        alu_a_sel = w_is_auipc;
        alu_b_sel = w_is_i | w_is_l | w_is_s | w_is_jalr | w_is_auipc;
        if (w_is_l) begin
            wb_sel = 2'd1;
        end else if (w_is_jal || w_is_jalr) begin
            wb_sel = 2'd2;
        end else if (w_is_lui) begin
            wb_sel = 2'd3;
        end else begin
            wb_sel = 2'd0;
        end

        case (r_state)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we  = 1'b1;
                    w_next = S_ID;
                end
            end
            S_ID: begin
                w_next = w_supported ? S_EX : S_TRAP;
            end
            S_EX: begin
                if (w_is_b) begin
                    // Branches retire here: pc_we is their single PC update.
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? 2'd1 : 2'd0;
                    w_next = S_IF;
                end else if (w_is_l || w_is_s) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_s;
                if (dmem_ack) begin
                    if (w_is_s) begin
                        // Stores have no writeback, so they retire on the ack.
                        pc_we  = 1'b1;
                        w_next = S_IF;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                if (w_is_jal) begin
                    pc_sel = 2'd1;
                end else if (w_is_jalr) begin
                    pc_sel = 2'd2;
                end
                w_next = S_IF;
            end
            S_TRAP: begin
                // Sticky until reset; every enable and request stays low.
                illegal = 1'b1;
                w_next  = S_TRAP;
            end
            default: begin
                // Unused encodings recover to fetch.
                w_next = S_IF;
            end
        endcase
    end

    assign state = r_state;

`ifdef MCTRL_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    // Cycle and retired-instruction counters; both freeze while trapped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt   <= 32'd0;
            r_instret_cnt <= 32'd0;
        end else if (r_state != S_TRAP) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (pc_we) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl. Expected values are hand-derived
// from the instruction-class routing and handshake rules of the controller.
module tb_multi_cycle_ctrl;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       br_taken;
    logic       imem_req;
    logic       imem_ack;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [2:0] state;
    logic       illegal;
`ifdef MCTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    multi_cycle_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .state     (state),
        .illegal   (illegal)
`ifdef MCTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Hard stop in case a wait escapes its own bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Runs one instruction from IF back to IF. imem_ack is tied high; the data
    // ack is given on request cycle number mem_wait (0 = zero wait).
    // seq collects the visited states as one hex nibble per cycle.
    task automatic run_instr(
        input  string       tag,
        input  logic [6:0]  op,
        input  int          mem_wait,
        input  logic        br,
        output logic [31:0] seq,
        output int          cycles,
        output int          n_rf,
        output int          n_pc,
        output int          n_dreq,
        output logic [1:0]  pcs,
        output logic [1:0]  wbs,
        output logic        asel,
        output logic        bsel,
        output logic        dwe
    );
        int req_seen;
        bit done;
        seq      = 32'd0;
        cycles   = 0;
        n_rf     = 0;
        n_pc     = 0;
        n_dreq   = 0;
        pcs      = 2'b11;
        wbs      = 2'b11;
        asel     = 1'bx;
        bsel     = 1'bx;
        dwe      = 1'bx;
        req_seen = 0;
        done     = 1'b0;
        opcode   = op;
        br_taken = br;
        imem_ack = 1'b1;
        while (!done && cycles < 40) begin
            dmem_ack = dmem_req && (req_seen >= mem_wait);
            #1;
            seq = {seq[27:0], 1'b0, state};
            cycles++;
            if (dmem_req) begin
                req_seen++;
                n_dreq++;
                dwe = dmem_we;
            end
            if (rf_we) begin
                n_rf++;
                wbs  = wb_sel;
                asel = alu_a_sel;
                bsel = alu_b_sel;
            end
            if (pc_we) begin
                n_pc++;
                pcs = pc_sel;
            end
            tick();
            if (state == 3'd0) done = 1'b1;
        end
        dmem_ack = 1'b0;
        check({tag, "_returned_to_if"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [31:0] seq;
        int          cycles, n_rf, n_pc, n_dreq, bad;
        logic [1:0]  pcs, wbs;
        logic        asel, bsel, dwe;
`ifdef MCTRL_PERF_EN
        logic [31:0] frozen_cyc, frozen_ret;
`endif

        rst_n    = 1'b0;
        opcode   = 7'd0;
        br_taken = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_state",    {29'd0, state}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd1);
        check("rst_quiet", {24'd0, dmem_req, dmem_we, ir_we, pc_we, rf_we, illegal, pc_sel}, 32'd0);

        // ir_we pulses in the same cycle as a zero-wait fetch ack.
        rst_n    = 1'b1;
        opcode   = OP_R;
        imem_ack = 1'b1;
        #1;
        check("if_ir_we", {31'd0, ir_we}, 32'd1);

        // ADD: IF, ID, EX, WB.
        run_instr("add", OP_R, 0, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("add_seq",    seq, 32'h0000_0124);
        check("add_rf_pc",  {n_rf[15:0], n_pc[15:0]}, 32'h0001_0001);
        check("add_wb_sel", {30'd0, wbs}, 32'd0);
        check("add_pc_sel", {30'd0, pcs}, 32'd0);
        check("add_dreq",   n_dreq, 32'd0);

        // LW with the data ack 3 cycles late: 4 request cycles, 8 cycles total.
        run_instr("lw", OP_L, 3, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("lw_seq",     seq, 32'h0123_3334);
        check("lw_cycles",  cycles, 32'd8);
        check("lw_dreq",    n_dreq, 32'd4);
        check("lw_dmem_we", {31'd0, dwe}, 32'd0);
        check("lw_wb_sel",  {30'd0, wbs}, 32'd1);
        check("lw_rf_pc",   {n_rf[15:0], n_pc[15:0]}, 32'h0001_0001);

        // BEQ taken then not taken: 3 cycles each, PC written in EX only.
        run_instr("beq_t", OP_B, 0, 1'b1, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("beq_t_seq",    seq, 32'h0000_0012);
        check("beq_t_rf_pc",  {n_rf[15:0], n_pc[15:0]}, 32'h0000_0001);
        check("beq_t_pc_sel", {30'd0, pcs}, 32'd1);
        run_instr("beq_n", OP_B, 0, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("beq_n_cycles", cycles, 32'd3);
        check("beq_n_rf_pc",  {n_rf[15:0], n_pc[15:0]}, 32'h0000_0001);
        check("beq_n_pc_sel", {30'd0, pcs}, 32'd0);

        // JALR: ALU target, link writeback, immediate operand.
        run_instr("jalr", OP_JALR, 0, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("jalr_seq",   seq, 32'h0000_0124);
        check("jalr_sels",  {26'd0, pcs, wbs, asel, bsel}, {26'd0, 2'd2, 2'd2, 1'b0, 1'b1});

        // JAL, LUI, AUIPC select patterns in WB.
        run_instr("jal", OP_JAL, 0, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("jal_sels",   {26'd0, pcs, wbs, asel, bsel}, {26'd0, 2'd1, 2'd2, 1'b0, 1'b0});
        run_instr("lui", OP_LUI, 0, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("lui_sels",   {26'd0, pcs, wbs, asel, bsel}, {26'd0, 2'd0, 2'd3, 1'b0, 1'b0});
        run_instr("auipc", OP_AUIPC, 0, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("auipc_sels", {26'd0, pcs, wbs, asel, bsel}, {26'd0, 2'd0, 2'd0, 1'b1, 1'b1});

        // SW zero wait: 4 cycles, retires from MEM, no register write.
        run_instr("sw", OP_S, 0, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("sw_seq",     seq, 32'h0000_0123);
        check("sw_dmem_we", {31'd0, dwe}, 32'd1);
        check("sw_rf_pc",   {n_rf[15:0], n_pc[15:0]}, 32'h0000_0001);
        check("sw_pc_sel",  {30'd0, pcs}, 32'd0);

        // Reset during MEM of a store abandons the request; a late ack is ignored.
        opcode   = OP_S;
        imem_ack = 1'b1;
        dmem_ack = 1'b0;
        tick();
        tick();
        tick();
        check("swr_in_mem", {29'd0, state, dmem_req, dmem_we}, {29'd3, 1'b1, 1'b1});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("swr_after_rst", {29'd0, state, dmem_req, 1'b0}, 32'd0);
        imem_ack = 1'b0;
        dmem_ack = 1'b1;
        #1;
        check("swr_late_ack_pc_we", {30'd0, pc_we, dmem_req}, 32'd0);
        tick();
        tick();
        check("swr_late_ack_state", {29'd0, state}, 32'd0);
        dmem_ack = 1'b0;

`ifdef MCTRL_PERF_EN
        // Counters: ADD + BEQ + SW retire 3 instructions in 4+3+4 cycles.
        do_reset();
        check("perf_rst", cycle_cnt | instret_cnt, 32'd0);
        run_instr("p_add", OP_R, 0, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        run_instr("p_beq", OP_B, 0, 1'b1, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        run_instr("p_sw",  OP_S, 0, 1'b0, seq, cycles, n_rf, n_pc, n_dreq, pcs, wbs, asel, bsel, dwe);
        check("perf_instret", instret_cnt, 32'd3);
        check("perf_cycles",  cycle_cnt, 32'd11);

        // Wrap of the cycle counter (held in IF with no fetch ack).
        imem_ack = 1'b0;
        force dut.r_cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycle_cnt;
        check("perf_force", cycle_cnt, 32'hFFFF_FFFE);
        tick();
        check("perf_max",   cycle_cnt, 32'hFFFF_FFFF);
        tick();
        check("perf_wrap",  cycle_cnt, 32'd0);
`endif

        // Unsupported opcode: trap after ID, then 20 quiet cycles.
        do_reset();
        opcode   = 7'b0000000;
        imem_ack = 1'b1;
        tick();
        check("trap_id",    {29'd0, state}, 32'd1);
        tick();
        check("trap_state", {29'd0, state}, 32'd5);
`ifdef MCTRL_PERF_EN
        frozen_cyc = cycle_cnt;
        frozen_ret = instret_cnt;
`endif
        dmem_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (illegal !== 1'b1 || imem_req || dmem_req || ir_we || pc_we || rf_we || state !== 3'd5)
                bad++;
            tick();
        end
        check("trap_held_quiet", bad, 32'd0);
`ifdef MCTRL_PERF_EN
        check("trap_cyc_frozen", cycle_cnt, frozen_cyc);
        check("trap_ret_frozen", instret_cnt, frozen_ret);
`endif
        dmem_ack = 1'b0;
        imem_ack = 1'b0;

        // Reset leaves the trap.
        do_reset();
        check("trap_exit", {30'd0, illegal, state == 3'd0}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
